// File: rtl/ws2812_pkg.sv
// Shared constants for the WS2812 LED controller: register map, FSM encoding
// and default bit timing at 85.90908 MHz.
`timescale 1ns/1ps
package ws2812_pkg;

  localparam logic [1:0] REG_G    = 2'd0;
  localparam logic [1:0] REG_R    = 2'd1;
  localparam logic [1:0] REG_B    = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } ws_state_e;

  // Cycle counts: 0.40 us / 0.80 us high, 1.25 us bit, 80 us latch gap
  localparam int T0H_DEF  = 34;
  localparam int T1H_DEF  = 69;
  localparam int TBIT_DEF = 107;
  localparam int TRES_DEF = 6873;

  // cnt must reach TRES-1; index counts 23 down to 0
  localparam int CNT_W = 13;
  localparam int IDX_W = 5;

endpackage

// File: rtl/ws2812_serializer.sv
// Serialises a 24-bit GRB word MSB first onto the single-wire WS2812 line,
// followed by a low latch gap. The bit counter runs across HIGH and LOW
// without clearing so every bit period is exactly TBIT cycles.
`timescale 1ns/1ps
module ws2812_serializer
  import ws2812_pkg::*;
#(
  parameter int T0H  = T0H_DEF,
  parameter int T1H  = T1H_DEF,
  parameter int TBIT = TBIT_DEF,
  parameter int TRES = TRES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] data,
  output logic        busy,
  output logic        dout
);

  localparam logic [CNT_W-1:0] T0H_M1  = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T1H_M1  = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] TBIT_M1 = CNT_W'(TBIT - 1);
  localparam logic [CNT_W-1:0] TRES_M1 = CNT_W'(TRES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(23);

  ws_state_e         state;
  logic [23:0]       shadow;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  th_m1;

  // High time of the bit currently at the top of the shadow register
  assign th_m1 = shadow[23] ? T1H_M1 : T0H_M1;

  // Frame FSM; dout and busy are registered so the line never glitches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      shadow <= '0;
      idx    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      dout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shadow <= data;
            idx    <= IDX_TOP;
            cnt    <= '0;
            state  <= HIGH;
            busy   <= 1'b1;
            dout   <= 1'b1;
          end
        end
        HIGH: begin
          cnt <= cnt + 1'b1;
          if (cnt == th_m1) begin
            state <= LOW;
            dout  <= 1'b0;
          end
        end
        LOW: begin
          if (cnt == TBIT_M1) begin
            cnt    <= '0;
            shadow <= {shadow[22:0], 1'b0};
            idx    <= idx - 1'b1;
            if (idx == '0) begin
              state <= GAP;
            end else begin
              state <= HIGH;
              dout  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == TRES_M1) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ws2812_led_ctrl.sv
// I/O-mapped WS2812 controller: G/R/B registers, trigger/status port and the
// bus handshake. Triggers stall while a frame (including its latch gap) runs.
`timescale 1ns/1ps
module ws2812_led_ctrl
  import ws2812_pkg::*;
#(
  parameter int T0H  = T0H_DEF,
  parameter int T1H  = T1H_DEF,
  parameter int TBIT = TBIT_DEF,
  parameter int TRES = TRES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] bus_address,
  input  logic       bus_ioreq,
  input  logic       bus_write,
  input  logic       bus_valid,
  output logic       bus_ready,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_rdata_en,
  output logic       busy,
  output logic       ws2812_led
);

  logic [7:0] reg_g, reg_r, reg_b;
  logic [7:0] rd_mux;
  logic       accept;
  logic       trig;

  // busy is high exactly while the serializer is outside IDLE
  assign bus_ready = !(bus_valid && bus_ioreq && bus_write &&
                       (bus_address == REG_CTRL) && busy);
  assign accept    = bus_valid && bus_ioreq && bus_ready;
  assign trig      = accept && bus_write && (bus_address == REG_CTRL);

  // Colour register writes, accepted in any state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_g <= 8'h00;
      reg_r <= 8'h00;
      reg_b <= 8'h00;
    end else if (accept && bus_write) begin
      case (bus_address)
        REG_G:   reg_g <= bus_wdata;
        REG_R:   reg_r <= bus_wdata;
        REG_B:   reg_b <= bus_wdata;
        default: ;
      endcase
    end
  end

  // Read data selection
  always_comb begin
    rd_mux = 8'h00;
    case (bus_address)
      REG_G:   rd_mux = reg_g;
      REG_R:   rd_mux = reg_r;
      REG_B:   rd_mux = reg_b;
      default: rd_mux = {7'd0, busy};
    endcase
  end

  // Registered read response: one-cycle strobe, data held until next read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_rdata    <= 8'h00;
      bus_rdata_en <= 1'b0;
    end else begin
      bus_rdata_en <= accept && !bus_write;
      if (accept && !bus_write) bus_rdata <= rd_mux;
    end
  end

  ws2812_serializer #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT),
    .TRES (TRES)
  ) u_ser (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (trig),
    .data    ({reg_g, reg_r, reg_b}),
    .busy    (busy),
    .dout    (ws2812_led)
  );

endmodule
